fetch_redirect: RTL
===================

# fetch_redirect

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipeline CPU. It is the receiving end of the EXE-stage branch flush: it consumes `ex_clear` and the branch target, squashes the IF/ID slot and any in-flight instruction-memory access, and restarts fetch at the target. It generates the PC, runs a req/ack handshake with instruction memory, and absorbs the hazard-unit stall with a one-entry hold buffer.

## Interface
- `XLEN`, 32: address/PC width (matches `datawidth`).
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_clear` in 1: branch taken in EXE (branch-unit `clear`).
- `ex_target` in XLEN: redirect address; bits [1:0] ignored (treated as 00).
- `stall` in 1: hazard unit holds IF/ID.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address, stable while `imem_req` is high.
- `imem_ack` in 1: transfer completes on a rising edge with `imem_req && imem_ack`; same-cycle ack allowed.
- `imem_rdata` in 32: instruction, valid with `imem_ack`.
- `id_valid` out 1; `id_pc` out XLEN; `id_instr` out 32: IF/ID register.

## Operation
- States: IDLE (nothing outstanding), WAIT (request issued, not acked), DROP (request outstanding, result to be discarded), HOLD (instruction parked in hold buffer).
- Slot free = `!id_valid || !stall`.
- `imem_req` = (IDLE && slot free && !ex_clear) || WAIT || DROP. `imem_addr` = `pc`.
- Once asserted, `imem_req` stays high until ack; it is never withdrawn.
- IDLE: ack in the issue cycle: accept, stay IDLE. No ack: go to WAIT.
- Accept (ack, not DROP, no `ex_clear`):
  - slot free: IF/ID <= {1, `pc`, `imem_rdata`}.
  - slot occupied: hold <= {`pc`, `imem_rdata`}, go to HOLD.
  - Either way, `pc` <= `pc`+4 (mod 2^XLEN).
- HOLD: no request. When `!stall`, IF/ID <= hold, go to IDLE.
- `ex_clear` (priority over `stall`):
  - IF/ID: `id_valid` <= 0.
  - IDLE: `pc` <= target.
  - HOLD: discard hold, `pc` <= target, go to IDLE.
  - WAIT with ack: discard data, `pc` <= target, go to IDLE.
  - WAIT without ack: `redir` <= target, go to DROP.
- DROP: a further `ex_clear` overwrites `redir` (latest wins). On ack: discard data, `pc` <= `redir` (or `ex_target` if `ex_clear` is in the same cycle), go to IDLE.
- IF/ID with `!stall` and no new instruction: `id_valid` <= 0 (bubble). With `stall` and no clear: IF/ID unchanged.
- Priority: `rst` > `ex_clear` > `stall` > normal fetch.

## Timing
- Reset values:
  - state IDLE; `pc` = `RESET_PC`.
  - `id_valid` 0, `id_pc` 0, `id_instr` 32'h0000_0013 (NOP).
  - `redir` 0; hold buffer 0.
  - `imem_req` 0 while `rst` is high.
  - First request in the first cycle after release.
- Reset mid-transaction abandons the access; memory must tolerate the dropped request.
- Zero-wait memory: one instruction per cycle; fetch-to-`id_valid` latency is 1 cycle.
- Redirect: `ex_clear` in cycle n → request to target in n+1 (IDLE/WAIT-with-ack/HOLD) → `id_valid` with target PC in n+2 on zero-wait memory. From DROP: request to target in the cycle after the discarded ack.
- `ex_clear` is ignored while `rst` is high.
- PC wrap at 0xFFFF_FFFC → 0x0000_0000, no flag.

## Configuration
- `FETCH_FLUSH_CNT_EN` defined: adds output `flush_cnt` [15:0].
  - Increments on every cycle with `ex_clear` high (rst low).
  - Saturates at 16'hFFFF; reset value 0.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Shared package/`defines.v`: state encoding (IDLE/WAIT/DROP/HOLD), NOP constant 32'h0000_0013, default `RESET_PC`, PC increment constant 4.
- One sub-module: `fetch_hold_buf` — one-entry {pc, instr} register with load/drain/flush controls.
- FSM, PC, redirect register and IF/ID register stay in the top module.

## Test plan
- Reset then zero-wait memory: `imem_addr` 0x0, 0x4, 0x8 on consecutive cycles; `id_pc` follows one cycle later with matching `id_instr`.
- 3-cycle-latency memory, `ex_clear` with target 0x100 in the second wait cycle → returned data discarded, `id_valid` stays 0, next `imem_addr` = 0x100.
- Two `ex_clear` pulses during DROP (targets 0x200, then 0x300) → fetch resumes at 0x300 only.
- `stall` high with `id_valid` = 1 when ack arrives for 0x8 → HOLD, no request; `stall` drops → `id_pc` = 0x8 next cycle, requests resume at 0xC.
- `ex_clear` together with `stall` in HOLD → `id_valid` 0, hold discarded, next `imem_addr` = target.
- With `FETCH_FLUSH_CNT_EN`: 5 clears → `flush_cnt` = 5; assert `rst` mid-WAIT → `imem_req` 0, `id_valid` 0, `flush_cnt` 0, restart at `RESET_PC`.

Source files
------------

// File: rtl/fetch_redirect_pkg.sv
// Shared definitions for the fetch/redirect stage: FSM encoding and fetch constants.
package fetch_redirect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_redirect_hold_buf.sv
// One-entry {pc, instr} buffer that parks a fetched instruction while IF/ID is stalled.
module fetch_hold_buf
    import fetch_redirect_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            drain,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic [XLEN-1:0] hold_pc,
    output logic [31:0]     hold_instr
);

    // Buffer contents; flush wins over load, draining clears the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pc    <= '0;
            hold_instr <= 32'h0000_0000;
        end else if (flush) begin
            hold_pc    <= '0;
            hold_instr <= 32'h0000_0000;
        end else if (load) begin
            hold_pc    <= load_pc;
            hold_instr <= load_instr;
        end else if (drain) begin
            hold_pc    <= '0;
            hold_instr <= 32'h0000_0000;
        end else begin
            hold_pc    <= hold_pc;
            hold_instr <= hold_instr;
        end
    end

endmodule

// File: rtl/fetch_redirect.sv
// Instruction fetch with branch redirect, imem req/ack handshake and IF/ID register.
// Optional FETCH_FLUSH_CNT_EN adds a saturating count of ex_clear cycles on flush_cnt.
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_clear,
    input  logic [XLEN-1:0] ex_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr
`ifdef FETCH_FLUSH_CNT_EN
    ,
    output logic [15:0]     flush_cnt
`endif
);

    fetch_state_t    state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] redir_r;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] pc_inc_s;
    logic            slot_free_s;
    logic            issue_s;
    logic            req_s;
    logic            xfer_s;
    logic            accept_s;
    logic            hold_load_s;
    logic            hold_flush_s;
    logic            drain_s;
    logic [XLEN-1:0] hold_pc_s;
    logic [31:0]     hold_instr_s;

    // Handshake and control decode for the current cycle.
    always_comb begin
        target_s     = ex_target & ~(XLEN'(2'b11));
        pc_inc_s     = pc_r + XLEN'(PC_INC);
        slot_free_s  = !id_valid || !stall;
        issue_s      = (state_r == ST_IDLE) && slot_free_s && !ex_clear;
        req_s        = 1'b0;
        if (rst) begin
            req_s = 1'b0;
        end else begin
            req_s = issue_s || (state_r == ST_WAIT) || (state_r == ST_DROP);
        end
        xfer_s       = req_s && imem_ack;
        accept_s     = xfer_s && (state_r != ST_DROP) && !ex_clear;
        hold_load_s  = accept_s && !slot_free_s;
        hold_flush_s = ex_clear && (state_r == ST_HOLD);
        drain_s      = (state_r == ST_HOLD) && !stall && !ex_clear;
    end

    assign imem_req  = req_s;
    assign imem_addr = pc_r;

    fetch_hold_buf #(
        .XLEN (XLEN)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load_s),
        .drain      (drain_s),
        .flush      (hold_flush_s),
        .load_pc    (pc_r),
        .load_instr (imem_rdata),
        .hold_pc    (hold_pc_s),
        .hold_instr (hold_instr_s)
    );

    // Fetch FSM, PC and redirect register; ex_clear outranks stall and normal fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            redir_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_clear) begin
                        pc_r <= target_s;
                    end else if (accept_s) begin
                        pc_r    <= pc_inc_s;
                        state_r <= hold_load_s ? ST_HOLD : ST_IDLE;
                    end else if (issue_s) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ex_clear && xfer_s) begin
                        pc_r    <= target_s;
                        state_r <= ST_IDLE;
                    end else if (ex_clear) begin
                        redir_r <= target_s;
                        state_r <= ST_DROP;
                    end else if (accept_s) begin
                        pc_r    <= pc_inc_s;
                        state_r <= hold_load_s ? ST_HOLD : ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DROP: begin
                    // The in-flight result is dead; a same-cycle clear beats the saved target.
                    if (xfer_s) begin
                        pc_r    <= ex_clear ? target_s : redir_r;
                        state_r <= ST_IDLE;
                    end else if (ex_clear) begin
                        redir_r <= target_s;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (ex_clear) begin
                        pc_r    <= target_s;
                        state_r <= ST_IDLE;
                    end else if (!stall) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // IF/ID pipeline register: squash, load fresh/parked instruction, bubble or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
        end else if (ex_clear) begin
            id_valid <= 1'b0;
        end else if (accept_s && slot_free_s) begin
            id_valid <= 1'b1;
            id_pc    <= pc_r;
            id_instr <= imem_rdata;
        end else if (drain_s) begin
            id_valid <= 1'b1;
            id_pc    <= hold_pc_s;
            id_instr <= hold_instr_s;
        end else if (!stall) begin
            id_valid <= 1'b0;
        end else begin
            id_valid <= id_valid;
        end
    end

`ifdef FETCH_FLUSH_CNT_EN
    // Saturating count of cycles with ex_clear asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 16'h0000;
        end else if (ex_clear && (flush_cnt != 16'hFFFF)) begin
            flush_cnt <= flush_cnt + 16'd1;
        end else begin
            flush_cnt <= flush_cnt;
        end
    end
`endif

endmodule
